// File: rtl/gpu_pkg.sv
//==============================================================================
// Module  : gpu_pkg
// Brief   : Shared types and constants for the GPU instruction path.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package gpu_pkg;

    localparam int INST_W = 32;

    localparam logic INST_SHAPE = 1'b0;
    localparam logic INST_ALPHA = 1'b1;

    localparam logic [1:0] SHAPE_LINE = 2'b00;
    localparam logic [1:0] SHAPE_RECT = 2'b01;
    localparam logic [1:0] SHAPE_TRI  = 2'b10;
    localparam logic [1:0] SHAPE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        DEC_FETCH0 = 2'd0,
        DEC_FETCH1 = 2'd1,
        DEC_FETCH2 = 2'd2,
        DEC_HOLD   = 2'd3
    } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_decoder.sv
//==============================================================================
// Module  : inst_decoder
// Brief   : Prefetches one shape/alpha instruction from the FIFO and hands
//           decoded fields to the drawing engines on read_en.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_decoder
    import gpu_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 24
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               fifo_empty,
    input  logic [INST_W-1:0]  fifo_rdata,
    output logic               fifo_pop,
    input  logic               read_en,
    output logic               inst_empty,
    output logic               inst_type,
    output logic [1:0]         shape_sel,
    output logic [COLOR_W-1:0] color,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y2,
    output logic [7:0]         alpha_val,
    output logic               bad_inst
);

    dec_state_t state_q, state_d;

    // Holding register for the instruction being assembled
    logic               held_type_q,  held_type_d;
    logic [1:0]         held_sel_q,   held_sel_d;
    logic [COLOR_W-1:0] held_color_q, held_color_d;
    logic [7:0]         held_alpha_q, held_alpha_d;
    logic [COORD_W-1:0] held_x1_q,    held_x1_d;
    logic [COORD_W-1:0] held_y1_q,    held_y1_d;
    logic [COORD_W-1:0] held_x2_q,    held_x2_d;
    logic [COORD_W-1:0] held_y2_q,    held_y2_d;

    // Output field bank
    logic [1:0]         shape_sel_q,  shape_sel_d;
    logic [COLOR_W-1:0] color_q,      color_d;
    logic [COORD_W-1:0] x1_q,         x1_d;
    logic [COORD_W-1:0] y1_q,         y1_d;
    logic [COORD_W-1:0] x2_q,         x2_d;
    logic [COORD_W-1:0] y2_q,         y2_d;
    logic [7:0]         alpha_val_q,  alpha_val_d;
    logic               bad_inst_q,   bad_inst_d;

    logic w_fetching;
    logic unused_rdata;

    // Word-0 bits [28:24] carry no meaning for either instruction type
    assign unused_rdata = ^fifo_rdata[28:24];

    assign w_fetching = (state_q != DEC_HOLD);
    assign fifo_pop   = w_fetching && !fifo_empty;
    assign inst_empty = w_fetching;
    assign inst_type  = !w_fetching && held_type_q;

    always_comb begin
        state_d      = state_q;
        held_type_d  = held_type_q;
        held_sel_d   = held_sel_q;
        held_color_d = held_color_q;
        held_alpha_d = held_alpha_q;
        held_x1_d    = held_x1_q;
        held_y1_d    = held_y1_q;
        held_x2_d    = held_x2_q;
        held_y2_d    = held_y2_q;
        shape_sel_d  = shape_sel_q;
        color_d      = color_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        x2_d         = x2_q;
        y2_d         = y2_q;
        alpha_val_d  = alpha_val_q;
        bad_inst_d   = 1'b0;

        case (state_q)
            DEC_FETCH0: begin
                if (!fifo_empty) begin
                    held_type_d  = fifo_rdata[31];
                    held_sel_d   = fifo_rdata[30:29];
                    held_color_d = fifo_rdata[COLOR_W-1:0];
                    held_alpha_d = fifo_rdata[23:16];
                    state_d      = (fifo_rdata[31] == INST_ALPHA) ? DEC_HOLD : DEC_FETCH1;
                end
            end
            DEC_FETCH1: begin
                if (!fifo_empty) begin
                    held_x1_d = COORD_W'(fifo_rdata[31:16]);
                    held_y1_d = COORD_W'(fifo_rdata[15:0]);
                    state_d   = DEC_FETCH2;
                end
            end
            DEC_FETCH2: begin
                if (!fifo_empty) begin
                    held_x2_d = COORD_W'(fifo_rdata[31:16]);
                    held_y2_d = COORD_W'(fifo_rdata[15:0]);
                    // Reserved shape is only rejected once all three words are drained
                    if (held_sel_q == SHAPE_RSVD) begin
                        bad_inst_d = 1'b1;
                        state_d    = DEC_FETCH0;
                    end else begin
                        state_d    = DEC_HOLD;
                    end
                end
            end
            DEC_HOLD: begin
                if (read_en) begin
                    if (held_type_q == INST_ALPHA) begin
                        alpha_val_d = held_alpha_q;
                    end else begin
                        shape_sel_d = held_sel_q;
                        color_d     = held_color_q;
                        x1_d        = held_x1_q;
                        y1_d        = held_y1_q;
                        x2_d        = held_x2_q;
                        y2_d        = held_y2_q;
                    end
                    state_d = DEC_FETCH0;
                end
            end
            default: state_d = DEC_FETCH0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= DEC_FETCH0;
            held_type_q  <= 1'b0;
            held_sel_q   <= 2'b00;
            held_color_q <= '0;
            held_alpha_q <= '0;
            held_x1_q    <= '0;
            held_y1_q    <= '0;
            held_x2_q    <= '0;
            held_y2_q    <= '0;
            shape_sel_q  <= 2'b00;
            color_q      <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            x2_q         <= '0;
            y2_q         <= '0;
            alpha_val_q  <= '0;
            bad_inst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_type_q  <= held_type_d;
            held_sel_q   <= held_sel_d;
            held_color_q <= held_color_d;
            held_alpha_q <= held_alpha_d;
            held_x1_q    <= held_x1_d;
            held_y1_q    <= held_y1_d;
            held_x2_q    <= held_x2_d;
            held_y2_q    <= held_y2_d;
            shape_sel_q  <= shape_sel_d;
            color_q      <= color_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            x2_q         <= x2_d;
            y2_q         <= y2_d;
            alpha_val_q  <= alpha_val_d;
            bad_inst_q   <= bad_inst_d;
        end
    end

    assign shape_sel = shape_sel_q;
    assign color     = color_q;
    assign x1        = x1_q;
    assign y1        = y1_q;
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign alpha_val = alpha_val_q;
    assign bad_inst  = bad_inst_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_decoder.sv
//==============================================================================
// Module  : tb_inst_decoder
// Brief   : Self-checking bench for inst_decoder with a FIFO model and an
//           expected-output scoreboard.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_decoder;

    logic        clk;
    logic        n_rst;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_pop;
    logic        read_en;
    logic        inst_empty;
    logic        inst_type;
    logic [1:0]  shape_sel;
    logic [23:0] color;
    logic [9:0]  x1, y1, x2, y2;
    logic [7:0]  alpha_val;
    logic        bad_inst;

    inst_decoder #(.COORD_W(10), .COLOR_W(24)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .read_en    (read_en),
        .inst_empty (inst_empty),
        .inst_type  (inst_type),
        .shape_sel  (shape_sel),
        .color      (color),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .alpha_val  (alpha_val),
        .bad_inst   (bad_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First-word-fall-through FIFO model; hide forces it to look empty
    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        hide   = 1'b0;
    int          pop_cnt = 0;
    int          pop_in_hold = 0;
    int          pop_on_empty = 0;
    int          bad_cnt = 0;

    assign fifo_empty = hide || (rd_ptr == wr_ptr);
    assign fifo_rdata = (rd_ptr < wr_ptr) ? mem[rd_ptr] : 32'h0;

    always @(posedge clk) begin
        if (n_rst && fifo_pop && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (n_rst && fifo_pop && !inst_empty) pop_in_hold <= pop_in_hold + 1;
        if (fifo_pop && fifo_empty)           pop_on_empty <= pop_on_empty + 1;
    end

    always @(negedge clk) if (bad_inst) bad_cnt <= bad_cnt + 1;

    // Expected output bank {shape_sel, color, x1, y1, x2, y2, alpha_val}
    typedef struct packed {
        logic [1:0]  sel;
        logic [23:0] color;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [9:0]  x2;
        logic [9:0]  y2;
        logic [7:0]  alpha;
    } out_t;

    typedef struct packed {
        logic typ;
        out_t out;
    } sb_t;

    out_t model;
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.sel   = shape_sel;
        o.color = color;
        o.x1    = x1;
        o.y1    = y1;
        o.x2    = x2;
        o.y2    = y2;
        o.alpha = alpha_val;
        return o;
    endfunction

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic expect_alpha(input logic [7:0] a);
        model.alpha = a;
        sb.push_back({1'b1, model});
    endtask

    task automatic push_alpha(input logic [7:0] a);
        push_word({1'b1, 7'h0, a, 16'h0});
        expect_alpha(a);
    endtask

    task automatic push_shape(input logic [1:0] sel, input logic [23:0] col,
                              input logic [15:0] ax1, input logic [15:0] ay1,
                              input logic [15:0] ax2, input logic [15:0] ay2);
        push_word({1'b0, sel, 5'h0, col});
        push_word({ax1, ay1});
        push_word({ax2, ay2});
        model.sel   = sel;
        model.color = col;
        model.x1    = ax1[9:0];
        model.y1    = ay1[9:0];
        model.x2    = ax2[9:0];
        model.y2    = ay2[9:0];
        sb.push_back({1'b0, model});
    endtask

    task automatic wait_hold(input string tag, input int budget);
        int n;
        n = 0;
        while (inst_empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (inst_empty) check({tag, "_timeout"}, 1, 0);
    endtask

    // Accept the held instruction and compare the output bank one cycle later
    task automatic accept(input string tag);
        sb_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_type"}, inst_type, e.typ);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        check({tag, "_fields"}, dut_out(), e.out);
        check({tag, "_empty_after"}, inst_empty, 1'b1);
    endtask

    initial begin
        int p0, b0;
        out_t prev;
        sb_t  e;

        n_rst   = 1'b0;
        read_en = 1'b0;
        model   = '0;

        // Reset with an alpha word already waiting
        push_word(32'h80AB0000);
        expect_alpha(8'hAB);
        @(negedge clk);
        @(negedge clk);
        check("rst_empty", inst_empty, 1'b1);
        check("rst_type",  inst_type,  1'b0);
        check("rst_fields", dut_out(), '0);
        check("rst_bad",   bad_inst,   1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        check("alpha_empty_n1", inst_empty, 1'b0);
        accept("alpha_ab");

        // Gap-free shape: exactly three pops, HOLD at the third cycle
        p0 = pop_cnt;
        push_shape(2'b01, 24'hFF0000, 16'h0005, 16'h0007, 16'h013F, 16'h00EF);
        check("w0_encode", mem[wr_ptr-3], 32'h20FF0000);
        @(negedge clk);
        @(negedge clk);
        check("shape_empty_n2", inst_empty, 1'b1);
        @(negedge clk);
        check("shape_empty_n3", inst_empty, 1'b0);
        repeat (3) @(negedge clk);
        check("shape_pops", pop_cnt - p0, 3);
        accept("shape_rect");

        // Same shape with two empty cycles before every word
        p0 = pop_cnt;
        push_shape(2'b10, 24'h123456, 16'h0005, 16'h0007, 16'h013F, 16'h00EF);
        for (int i = 0; i < 3; i++) begin
            hide = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("gap_empty", inst_empty, 1'b1);
            hide = 1'b0;
            @(negedge clk);
        end
        check("gap_hold", inst_empty, 1'b0);
        check("gap_pops", pop_cnt - p0, 3);
        accept("shape_gap");

        // Reserved shape is drained, flagged once, never presented
        b0 = bad_cnt;
        push_word(32'h60000000);
        push_word(32'h00010002);
        push_word(32'h00030004);
        @(negedge clk);
        @(negedge clk);
        check("bad_early", bad_cnt - b0, 0);
        @(negedge clk);
        check("bad_pulse", bad_inst, 1'b1);
        check("bad_empty", inst_empty, 1'b1);
        repeat (3) @(negedge clk);
        check("bad_once", bad_cnt - b0, 1);
        check("bad_fields", dut_out(), model);
        push_alpha(8'h12);
        wait_hold("alpha12", 4);
        accept("alpha_after_bad");

        // Back-to-back alphas re-presented two cycles after acceptance
        push_alpha(8'h34);
        push_alpha(8'h56);
        wait_hold("alpha34", 4);
        accept("alpha34");
        @(negedge clk);
        check("b2b_represent", inst_empty, 1'b0);
        accept("alpha56");

        // read_en held high through the fetch, then once more after acceptance
        prev = model;
        push_shape(2'b00, 24'h00ABCD, 16'h0100, 16'h0200, 16'h03FF, 16'h0001);
        read_en = 1'b1;
        @(negedge clk);
        check("re_fetch1", dut_out(), prev);
        @(negedge clk);
        check("re_fetch2", dut_out(), prev);
        check("re_fetch2_empty", inst_empty, 1'b1);
        @(negedge clk);
        check("re_hold", inst_empty, 1'b0);
        check("re_hold_fields", dut_out(), prev);
        e = sb.pop_front();
        check("re_type", inst_type, e.typ);
        @(negedge clk);
        check("re_accept", dut_out(), e.out);
        check("re_accept_empty", inst_empty, 1'b1);
        read_en = 1'b0;
        @(negedge clk);
        check("re_stable", dut_out(), e.out);

        // Reset after word 1 of a shape; the following word becomes word 0
        push_word(32'h40777777);
        push_word(32'h00090009);
        push_word(32'h80CD0000);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("mid_rst_fields", dut_out(), '0);
        check("mid_rst_empty", inst_empty, 1'b1);
        check("mid_rst_type",  inst_type,  1'b0);
        model = '0;
        @(negedge clk);
        n_rst = 1'b1;
        expect_alpha(8'hCD);
        @(negedge clk);
        check("mid_rst_hold", inst_empty, 1'b0);
        accept("alpha_cd");

        repeat (3) @(negedge clk);
        check("pop_in_hold", pop_in_hold, 0);
        check("pop_on_empty", pop_on_empty, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
